cerr_thresh_prog_ctrl: RTL

CERR_THRESH_PROG_CTRL -- requirements
Module: cerr_thresh_prog_ctrl

---
 rtl/cerr_thresh_prog_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cerr_thresh_prog_ctrl.sv
// Correctable-error threshold programming controller.
// Two level-style requesters (software and a BIST default loader) compete for
// a single valid/ack channel toward the threshold consumer. Each grant runs one
// transfer: the chosen threshold is presented until the consumer accepts it or
// a bounded wait expires, after which the requester receives a one-cycle done
// pulse qualified by done_err. A round-robin pointer alternates grants when
// both requesters are pending.
module cerr_thresh_prog_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       bist_clk,
    input  logic       reset_n,
    input  logic       sw_req,
    input  logic [7:0] sw_threshold,
    output logic       sw_done,
    input  logic       bist_req,
    input  logic [7:0] bist_threshold,
    output logic       bist_done,
    output logic       cerr_threshold_vld,
    input  logic       cerr_threshold_ack,
    output logic [7:0] cerr_threshold,
    output logic [7:0] cur_threshold,
    output logic       done_err,
    output logic       timeout_sticky,
    input  logic       timeout_clr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_CMPL = 2'd2;

    // Requester identity encoding used by the owner and pointer registers.
    localparam logic OWNER_SW   = 1'b0;
    localparam logic OWNER_BIST = 1'b1;

    // The counter value seen during the last permitted waiting cycle; an
    // unacknowledged edge with this value is the edge at which the count
    // reaches TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state_reg,     state_next;
    logic       vld_reg,       vld_next;
    logic [7:0] thr_reg,       thr_next;
    logic [7:0] cur_reg,       cur_next;
    logic       sw_done_reg,   sw_done_next;
    logic       bist_done_reg, bist_done_next;
    logic       err_reg,       err_next;
    logic       sticky_reg,    sticky_next;
    logic [7:0] cnt_reg,       cnt_next;
    logic       last_reg,      last_next;
    logic       owner_reg,     owner_next;

    logic       grant_bist;
    logic       timeout_event;

    // Round-robin choice: BIST wins only if it is alone or software was the
    // most recent grant.
    always_comb begin
        grant_bist = bist_req & (~sw_req | (last_reg == OWNER_SW));
    end

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_next     = state_reg;
        vld_next       = vld_reg;
        thr_next       = thr_reg;
        cur_next       = cur_reg;
        sw_done_next   = 1'b0;
        bist_done_next = 1'b0;
        err_next       = 1'b0;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        owner_next     = owner_reg;
        timeout_event  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (sw_req || bist_req) begin
                    owner_next = grant_bist;
                    last_next  = grant_bist;
                    thr_next   = grant_bist ? bist_threshold : sw_threshold;
                    vld_next   = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = S_BUSY;
                end
            end

            S_BUSY: begin
                if (cerr_threshold_ack) begin
                    // Acceptance has priority over an expiring wait.
                    vld_next       = 1'b0;
                    cur_next       = thr_reg;
                    sw_done_next   = (owner_reg == OWNER_SW);
                    bist_done_next = (owner_reg == OWNER_BIST);
                    cnt_next       = 8'd0;
                    state_next     = S_CMPL;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    vld_next       = 1'b0;
                    sw_done_next   = (owner_reg == OWNER_SW);
                    bist_done_next = (owner_reg == OWNER_BIST);
                    err_next       = 1'b1;
                    timeout_event  = 1'b1;
                    cnt_next       = 8'd0;
                    state_next     = S_CMPL;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            S_CMPL: begin
                // Done pulse is visible this cycle; requesters drop their
                // request before the next arbitration in IDLE.
                state_next = S_IDLE;
            end

            default: begin
                vld_next   = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Sticky timeout flag: a new timeout outranks a simultaneous clear.
    always_comb begin
        sticky_next = sticky_reg;
        if (timeout_event) begin
            sticky_next = 1'b1;
        end else if (timeout_clr) begin
            sticky_next = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge bist_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            vld_reg       <= 1'b0;
            thr_reg       <= 8'h00;
            cur_reg       <= 8'h00;
            sw_done_reg   <= 1'b0;
            bist_done_reg <= 1'b0;
            err_reg       <= 1'b0;
            sticky_reg    <= 1'b0;
            cnt_reg       <= 8'd0;
            last_reg      <= OWNER_BIST;
            owner_reg     <= OWNER_SW;
        end else begin
            state_reg     <= state_next;
            vld_reg       <= vld_next;
            thr_reg       <= thr_next;
            cur_reg       <= cur_next;
            sw_done_reg   <= sw_done_next;
            bist_done_reg <= bist_done_next;
            err_reg       <= err_next;
            sticky_reg    <= sticky_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            owner_reg     <= owner_next;
        end
    end

    assign cerr_threshold_vld = vld_reg;
    assign cerr_threshold     = thr_reg;
    assign cur_threshold      = cur_reg;
    assign sw_done            = sw_done_reg;
    assign bist_done          = bist_done_reg;
    assign done_err           = err_reg;
    assign timeout_sticky     = sticky_reg;

endmodule
